// File: rtl/mul_seq_32.sv
// Sequential unsigned 32x32 -> 64 shift-add multiplier built around a single
// time-multiplexed add_32 instance; valid/ready request and response channels.

module add_32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic [31:0] sum,
    output logic        c
);
    localparam int unsigned W  = 32;
    localparam int unsigned GW = 4;
    localparam int unsigned NG = W / GW;

    logic [W-1:0]  gen;
    logic [W-1:0]  prop;
    logic [W-1:0]  carry;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;

    // Two-level carry lookahead: 4-bit groups, group carries resolved first,
    // then in-group carries derived from each group's carry-in.
    always_comb begin
        gen   = x & y;
        prop  = x ^ y;
        grp_g = '0;
        grp_p = '1;
        grp_c = '0;
        carry = '0;
        for (int i = 0; i < int'(NG); i++) begin
            for (int k = 0; k < int'(GW); k++) begin
                grp_g[i] = gen[i*GW+k] | (prop[i*GW+k] & grp_g[i]);
                grp_p[i] = grp_p[i] & prop[i*GW+k];
            end
        end
        for (int i = 0; i < int'(NG); i++) begin
            grp_c[i+1] = grp_g[i] | (grp_p[i] & grp_c[i]);
        end
        for (int i = 0; i < int'(NG); i++) begin
            carry[i*GW] = grp_c[i];
            for (int k = 1; k < int'(GW); k++) begin
                carry[i*GW+k] = gen[i*GW+k-1] | (prop[i*GW+k-1] & carry[i*GW+k-1]);
            end
        end
        sum = prop ^ carry;
        c   = grp_c[NG];
    end
endmodule

module mul_seq_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  mcand;
    logic [W-1:0]  mq;
    logic [W-1:0]  acc_hi;
    logic [CW-1:0] count;

    logic [W-1:0]  addend;
    logic [W-1:0]  add_sum;
    logic          add_c;

    assign addend = mq[0] ? mcand : '0;

    add_32 u_add (
        .x   (acc_hi),
        .y   (addend),
        .sum (add_sum),
        .c   (add_c)
    );

    assign product = {acc_hi, mq};

    // Sequencer; handshake flags are registered alongside the state so they
    // follow the state register only and never see in_valid/out_ready directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mcand     <= '0;
            mq        <= '0;
            acc_hi    <= '0;
            count     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand    <= a;
                        mq       <= b;
                        acc_hi   <= '0;
                        count    <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    // The carry out lands in acc_hi[31]; acc_hi + mcand never exceeds 33 bits.
                    acc_hi <= {add_c, add_sum[W-1:1]};
                    mq     <= {add_sum[0], mq[W-1:1]};
                    count  <= count + CW'(1);
                    if (count == LAST_ITER) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul_seq_32.sv
// Directed and randomised self-checking bench for mul_seq_32.

module tb_mul_seq_32;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int n_tests;
    int n_fail;
    int cyc_cnt;
    int last_acc;
    bit chk_interval;

    mul_seq_32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue-interval monitor: acceptance edges must be at least 34 cycles apart.
    always @(posedge clk) begin
        cyc_cnt = cyc_cnt + 1;
        if (chk_interval && in_valid && in_ready) begin
            if (last_acc >= 0)
                check_eq("issue_interval_ge_34", 64'((cyc_cnt - last_acc) >= 34), 64'd1);
            last_acc = cyc_cnt;
        end
    end

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'd32);
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic [63:0] exp,
                          input int stall, input string tag);
        int cyc;
        int lat;
        cyc = 0;
        while (!in_ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_eq({tag, "_in_ready_calc"}, 64'(in_ready), 64'd0);
        check_eq({tag, "_busy_calc"}, 64'(busy), 64'd1);
        wait_done(tag, lat);
        check_eq({tag, "_product"}, product, exp);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            check_eq({tag, "_product_stall"}, product, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq({tag, "_out_valid_after_hs"}, 64'(out_valid), 64'd0);
        check_eq({tag, "_in_ready_after_hs"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int lat;
        int quiet;
        logic [31:0] ra;
        logic [31:0] rb;
        n_tests = 0;
        n_fail = 0;
        cyc_cnt = 0;
        last_acc = -1;
        chk_interval = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_product", product, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1..3: basic products and latency
        run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, 0, "t1_3x5");
        check_eq("t1_busy_idle", 64'(busy), 64'd0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, "t2_max");
        run_op(32'd0, 32'h1234_5678, 64'd0, 0, "t3_zero");
        run_op(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000, 0, "t3_msb");

        // 4: stall in DONE with new operands presented throughout
        a = 32'd7;
        b = 32'd9;
        in_valid = 1'b1;
        @(negedge clk);
        wait_done("t4_first", lat);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("t4_hold_product", product, 64'd63);
            check_eq("t4_hold_out_valid", 64'(out_valid), 64'd1);
            check_eq("t4_hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_eq("t4_in_ready_after_hs", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("t4_reaccepted", 64'(in_ready), 64'd0);
        wait_done("t4_second", lat);
        check_eq("t4_second_product", product, 64'd63);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // 5: asynchronous reset mid-CALC
        a = 32'hDEAD_BEEF;
        b = 32'h0000_0010;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (15) @(negedge clk);
        check_eq("t5_busy_before_rst", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("t5_async_in_ready", 64'(in_ready), 64'd1);
        check_eq("t5_async_out_valid", 64'(out_valid), 64'd0);
        check_eq("t5_async_busy", 64'(busy), 64'd0);
        check_eq("t5_async_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) quiet++;
        end
        check_eq("t5_no_out_valid", 64'(quiet), 64'd0);
        run_op(32'd2, 32'd2, 64'd4, 0, "t5_2x2");

        // 6: back-to-back random operands with random stalls
        chk_interval = 1'b1;
        last_acc = -1;
        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i == 0) ra = 32'hFFFF_FFFF;
            run_op(ra, rb, 64'(ra) * 64'(rb), int'($urandom_range(0, 3)), "t6_rand");
        end
        chk_interval = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
